// File: rtl/passcode_ctrl.sv
// Passcode lock sequencer: collects four button digits, compares them against CODE and drives
// the display state/correct/show lines. Lockout after repeated failures is built when PASSCODE_LOCKOUT_EN is defined.
module passcode_ctrl #(
    parameter logic [7:0] CODE          = 8'b00_01_10_11,
    parameter int         HOLD_CYCLES   = 100_000_000,
    parameter int         ENTRY_TIMEOUT = 500_000_000,
    parameter int         MAX_FAIL      = 3,
    parameter int         LOCK_CYCLES   = 1_000_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    output logic [2:0] state_o,
    output logic       correct_o,
    output logic       show_o,
    output logic       locked_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_GOT1 = 3'b001,
        S_GOT2 = 3'b010,
        S_GOT3 = 3'b100,
        S_PASS = 3'b011,
        S_FAIL = 3'b111,
        S_LOCK = 3'b110
    } state_t;

    localparam int DWELL_A   = (HOLD_CYCLES > ENTRY_TIMEOUT) ? HOLD_CYCLES : ENTRY_TIMEOUT;
    localparam int DWELL_MAX = (DWELL_A > LOCK_CYCLES) ? DWELL_A : LOCK_CYCLES;
    localparam int DW        = $clog2(DWELL_MAX + 1);

    state_t          state_q, state_d;
    logic [3:0]      btn_q;
    logic            mismatch_q, mismatch_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            correct_q, show_q;

    logic [3:0]      rise;
    logic            press;
    logic            digit_ok;
    logic [1:0]      digit;
    logic [1:0]      exp_digit;
    logic            wrong;
    logic            hold_done;
    logic            entry_expired;
    logic            lock_done;

`ifdef PASSCODE_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [FW-1:0]   fail_q, fail_d;
    logic            locked_q;
`endif

    always_comb begin
        rise     = btn_i & ~btn_q;
        press    = |rise;
        digit_ok = $onehot(rise);
        digit    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) digit = 2'(i);
        end
        case (state_q)
            S_GOT1:  exp_digit = CODE[5:4];
            S_GOT2:  exp_digit = CODE[3:2];
            S_GOT3:  exp_digit = CODE[1:0];
            default: exp_digit = CODE[7:6];
        endcase
        wrong         = !digit_ok || (digit != exp_digit);
        hold_done     = (dwell_q == DW'(HOLD_CYCLES - 1));
        entry_expired = (dwell_q == DW'(ENTRY_TIMEOUT - 1));
        lock_done     = (dwell_q == DW'(LOCK_CYCLES - 1));
    end

    always_comb begin
        state_d    = state_q;
        mismatch_d = mismatch_q;
        dwell_d    = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
        fail_d     = fail_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d    = S_GOT1;
                    mismatch_d = wrong;
                end
            end
            S_GOT1, S_GOT2: begin
                if (press) begin
                    state_d    = (state_q == S_GOT1) ? S_GOT2 : S_GOT3;
                    mismatch_d = mismatch_q | wrong;
                end else if (entry_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_GOT3: begin
                if (press) begin
                    mismatch_d = mismatch_q | wrong;
                    if (mismatch_q || wrong) begin
                        state_d = S_FAIL;
`ifdef PASSCODE_LOCKOUT_EN
                        fail_d  = (fail_q == '1) ? fail_q : fail_q + 1'b1;
`endif
                    end else begin
                        state_d = S_PASS;
`ifdef PASSCODE_LOCKOUT_EN
                        fail_d  = '0;
`endif
                    end
                end else if (entry_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_PASS: begin
                if (hold_done) state_d = S_IDLE;
            end
            S_FAIL: begin
                if (hold_done) begin
`ifdef PASSCODE_LOCKOUT_EN
                    if (fail_q >= FW'(MAX_FAIL)) begin
                        state_d = S_LOCK;
                        fail_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            S_LOCK: begin
                if (lock_done) begin
                    state_d = S_IDLE;
`ifdef PASSCODE_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        // every accepted press also changes state, so this covers both clear conditions
        if (state_d != state_q) dwell_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            btn_q      <= 4'b0000;
            mismatch_q <= 1'b0;
            dwell_q    <= '0;
            correct_q  <= 1'b0;
            show_q     <= 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
            fail_q     <= '0;
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_i;
            mismatch_q <= mismatch_d;
            dwell_q    <= dwell_d;
            correct_q  <= (state_d == S_PASS);
            show_q     <= (state_d != S_IDLE);
`ifdef PASSCODE_LOCKOUT_EN
            fail_q     <= fail_d;
            locked_q   <= (state_d == S_LOCK);
`endif
        end
    end

    assign state_o   = state_q;
    assign correct_o = correct_q;
    assign show_o    = show_q;
`ifdef PASSCODE_LOCKOUT_EN
    assign locked_o  = locked_q;
`else
    assign locked_o  = 1'b0;
`endif

endmodule

// File: tb/tb_passcode_ctrl.sv
// Directed bench for passcode_ctrl: vector table for the basic flows plus hand-written
// sequences for timeout, lockout and asynchronous reset.
module tb_passcode_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] btn_i;
    logic [2:0] state_o;
    logic       correct_o;
    logic       show_o;
    logic       locked_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] B0 = 4'b0001, B1 = 4'b0010, B2 = 4'b0100, B3 = 4'b1000, BN = 4'b0000;

    passcode_ctrl #(
        .CODE          (8'b00_01_10_11),
        .HOLD_CYCLES   (4),
        .ENTRY_TIMEOUT (10),
        .MAX_FAIL      (2),
        .LOCK_CYCLES   (6)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .btn_i     (btn_i),
        .state_o   (state_o),
        .correct_o (correct_o),
        .show_o    (show_o),
        .locked_o  (locked_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] btn;
        logic [2:0] st;
        logic       c;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] b, input logic [2:0] st, input logic c);
        vec_t v;
        v.btn = b;
        v.st  = st;
        v.c   = c;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic c, input logic s,
                         input logic l);
        n_checks++;
        if ({state_o, correct_o, show_o, locked_o} === {st, c, s, l}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got state=%b correct=%b show=%b locked=%b, expected state=%b correct=%b show=%b locked=%b",
                     name, state_o, correct_o, show_o, locked_o, st, c, s, l);
        end
    endtask

    // one clock: drive buttons, take the edge, sample just after it
    task automatic cyc(input logic [3:0] b, input logic [2:0] st, input logic c, input logic l,
                       input string name);
        btn_i = b;
        @(posedge clk_i);
        #1;
        check(name, st, c, (st != 3'b000), l);
    endtask

    task automatic enter3(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2);
        cyc(b0, 3'b001, 1'b0, 1'b0, "digit1");
        cyc(BN, 3'b001, 1'b0, 1'b0, "digit1_rel");
        cyc(b1, 3'b010, 1'b0, 1'b0, "digit2");
        cyc(BN, 3'b010, 1'b0, 1'b0, "digit2_rel");
        cyc(b2, 3'b100, 1'b0, 1'b0, "digit3");
        cyc(BN, 3'b100, 1'b0, 1'b0, "digit3_rel");
    endtask

    task automatic run_code(input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                            input logic [3:0] b3, input logic exp_pass, input logic to_lock);
        logic [2:0] fs;
        fs = exp_pass ? 3'b011 : 3'b111;
        enter3(b0, b1, b2);
        cyc(b3, fs, exp_pass, 1'b0, exp_pass ? "pass_entry" : "fail_entry");
        for (int i = 0; i < 3; i++) cyc(BN, fs, exp_pass, 1'b0, "result_hold");
`ifdef PASSCODE_LOCKOUT_EN
        if (to_lock) begin
            cyc(BN, 3'b110, 1'b0, 1'b1, "lock_entry");
            for (int i = 0; i < 5; i++)
                cyc((i % 2 == 0) ? B0 : BN, 3'b110, 1'b0, 1'b1, "lock_hold");
        end
`else
        if (to_lock) begin
            cyc(BN, 3'b000, 1'b0, 1'b0, "no_lock_idle");
            cyc(B2, 3'b001, 1'b0, 1'b0, "no_lock_press");
            for (int i = 0; i < 9; i++) cyc(BN, 3'b001, 1'b0, 1'b0, "no_lock_wait");
        end
`endif
        cyc(BN, 3'b000, 1'b0, 1'b0, "back_to_idle");
    endtask

    task automatic do_reset(input string name);
        btn_i = BN;
        #2;
        rst_i = 1'b1;
        #1;
        check({name, "_async"}, 3'b000, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        check({name, "_held"}, 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        btn_i = BN;

        add(BN, 3'b000, 0);
        add(B0, 3'b001, 0); add(BN, 3'b001, 0);
        add(B1, 3'b010, 0); add(BN, 3'b010, 0);
        add(B2, 3'b100, 0); add(BN, 3'b100, 0);
        add(B3, 3'b011, 1); add(BN, 3'b011, 1);
        add(B0, 3'b011, 1); add(BN, 3'b011, 1);
        add(BN, 3'b000, 0);

        add(B0, 3'b001, 0); add(BN, 3'b001, 0);
        add(B1, 3'b010, 0); add(BN, 3'b010, 0);
        add(B2, 3'b100, 0); add(BN, 3'b100, 0);
        add(B2, 3'b111, 0); add(BN, 3'b111, 0);
        add(BN, 3'b111, 0); add(BN, 3'b111, 0);
        add(BN, 3'b000, 0);

        add(B0, 3'b001, 0);
        for (int i = 0; i < 4; i++) add(B0, 3'b001, 0);
        add(BN, 3'b001, 0);
        add(B1, 3'b010, 0); add(BN, 3'b010, 0);
        add(B2, 3'b100, 0); add(BN, 3'b100, 0);
        add(B3, 3'b011, 1); add(BN, 3'b011, 1);
        add(BN, 3'b011, 1); add(BN, 3'b011, 1);
        add(BN, 3'b000, 0);

        add(4'b0011, 3'b001, 0); add(BN, 3'b001, 0);
        add(B1, 3'b010, 0); add(BN, 3'b010, 0);
        add(B2, 3'b100, 0); add(BN, 3'b100, 0);
        add(B3, 3'b111, 0); add(BN, 3'b111, 0);
        add(BN, 3'b111, 0); add(BN, 3'b111, 0);
        add(BN, 3'b000, 0);

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_state", 3'b000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (tbl[i]) cyc(tbl[i].btn, tbl[i].st, tbl[i].c, 1'b0, $sformatf("vec%0d", i));

        // entry timeout from GOT1
        cyc(B0, 3'b001, 1'b0, 1'b0, "to_press");
        for (int i = 0; i < 9; i++) cyc(BN, 3'b001, 1'b0, 1'b0, "to_wait");
        cyc(BN, 3'b000, 1'b0, 1'b0, "to_fire");

        // press on the timeout edge wins, then timeout from GOT2
        cyc(B0, 3'b001, 1'b0, 1'b0, "tw_press");
        for (int i = 0; i < 9; i++) cyc(BN, 3'b001, 1'b0, 1'b0, "tw_wait");
        cyc(B1, 3'b010, 1'b0, 1'b0, "tw_press_wins");
        for (int i = 0; i < 9; i++) cyc(BN, 3'b010, 1'b0, 1'b0, "tw_wait2");
        cyc(BN, 3'b000, 1'b0, 1'b0, "tw_fire2");

        // one failure already recorded and the timeouts left it alone: this one locks
        run_code(B0, B1, B2, B2, 1'b0, 1'b1);
        run_code(B0, B1, B2, B2, 1'b0, 1'b0);
        run_code(B0, B1, B2, B2, 1'b0, 1'b1);
        run_code(B0, B1, B2, B3, 1'b1, 1'b0);

        cyc(B0, 3'b001, 1'b0, 1'b0, "rg_d1");
        cyc(BN, 3'b001, 1'b0, 1'b0, "rg_d1_rel");
        cyc(B1, 3'b010, 1'b0, 1'b0, "rg_d2");
        do_reset("rst_got2");
        run_code(B0, B1, B2, B3, 1'b1, 1'b0);

        run_code(B3, B1, B2, B3, 1'b0, 1'b0);
        enter3(B0, B1, B2);
        cyc(B2, 3'b111, 1'b0, 1'b0, "rl_fail");
        for (int i = 0; i < 3; i++) cyc(BN, 3'b111, 1'b0, 1'b0, "rl_fail_hold");
`ifdef PASSCODE_LOCKOUT_EN
        cyc(BN, 3'b110, 1'b0, 1'b1, "rl_lock");
        cyc(B0, 3'b110, 1'b0, 1'b1, "rl_lock2");
`endif
        do_reset("rst_lock");
        run_code(B0, B1, B2, B2, 1'b0, 1'b0);
        run_code(B0, B1, B2, B3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/passcode_ctrl.md
# passcode_ctrl

Sequencing controller for the passcode lock. Collects a four-digit code from four push-buttons, compares it against a stored code, and drives the `state`/`correct`/`show` inputs of the seven-segment display driver so it shows entry progress, PASS or FAIL. Optionally enforces a lockout after repeated failures.

## Interface
- `CODE`, 8'b00_01_10_11: stored passcode, four 2-bit digits; first digit in [7:6], last in [1:0].
- `HOLD_CYCLES`, 100_000_000: cycles PASS/FAIL is held before returning to IDLE.
- `ENTRY_TIMEOUT`, 500_000_000: cycles without a press during partial entry before abandoning entry.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (lockout build only).
- `LOCK_CYCLES`, 1_000_000_000: lockout duration (lockout build only).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn` in 4: debounced, clk-synchronous buttons; `btn[i]` enters digit i.
- `state` out 3: display state code.
- `correct` out 1: high only in PASS.
- `show` out 1: display enable.
- `locked` out 1: high in LOCK (tied 0 when lockout compiled out).

## Operation
- Press detection: `btn_q` registers `btn`; `rise = btn & ~btn_q`. One press = cycle with `rise != 0`. Exactly one bit set → digit = its index. More than one bit set → one press with invalid digit (forces mismatch).
- Presses ignored in PASS, FAIL and LOCK; held buttons never repeat.
- `state` encodings: IDLE 3'b000, GOT1 3'b001, GOT2 3'b010, GOT3 3'b100, PASS 3'b011, FAIL 3'b111, LOCK 3'b110.
- Transitions:
  - IDLE -press-> GOT1; GOT1 -press-> GOT2; GOT2 -press-> GOT3.
  - GOT3 -press-> PASS if all four digits matched, else FAIL.
  - GOT1/2/3 with no press for ENTRY_TIMEOUT consecutive cycles -> IDLE; not a failure, fail count unchanged.
  - PASS/FAIL -> IDLE after HOLD_CYCLES cycles.
  - FAIL -> LOCK instead of IDLE when fail count reaches MAX_FAIL (lockout build).
  - LOCK -> IDLE after LOCK_CYCLES cycles; fail count cleared.
- Mismatch flag: cleared entering GOT1 from IDLE, set sticky on any wrong or invalid digit. No early abort; all four digits always collected.
- Fail count: saturating, width $clog2(MAX_FAIL+1); +1 on entry to FAIL; cleared on entry to PASS and to LOCK.
- Outputs: `show` = 1 in every state except IDLE. `correct` = 1 in PASS only. `locked` = 1 in LOCK only.
- One shared dwell counter, width covering the largest of HOLD_CYCLES, ENTRY_TIMEOUT and LOCK_CYCLES. Cleared on every state change and on every accepted press; saturates, never wraps.

## Timing
- Reset (async assert, sync release): state IDLE, `correct` 0, `show` 0, `locked` 0, `btn_q` 0, mismatch 0, fail count 0, dwell counter 0.
- Reset mid-entry, mid-hold or mid-lock: immediate return to IDLE; all progress and fail history lost.
- Press latency: registered state/outputs update on the same clk edge at which `btn` is first sampled 1 with `btn_q` 0. Visible one edge after `btn` rises.
- PASS/FAIL visible for exactly HOLD_CYCLES cycles, then IDLE.
- LOCK visible for exactly LOCK_CYCLES cycles.
- Timeout: IDLE on the edge where the no-press count reaches ENTRY_TIMEOUT. A press on that same edge wins; it is accepted and the timeout does not fire.
- Outputs are registered; no combinational input-to-output path.

## Configuration
- Macro: `PASSCODE_LOCKOUT_EN`.
- Defined: fail counter and LOCK state built; `MAX_FAIL` and `LOCK_CYCLES` active; FAIL goes to LOCK at the threshold.
- Undefined: no fail counter, LOCK state unreachable; FAIL always returns to IDLE; `locked` tied 0; `MAX_FAIL` and `LOCK_CYCLES` unused.

## Test plan
Bench parameters: CODE=8'b00_01_10_11, HOLD_CYCLES=4, ENTRY_TIMEOUT=10, MAX_FAIL=2, LOCK_CYCLES=6.
- Reset then press btn[0],[1],[2],[3] (one cycle each, gaps) -> state 001,010,100, then 011 with `correct`=1, `show`=1 for 4 cycles, then 000 with `show`=0.
- Press btn[0],[1],[2],[2] -> 111, `correct`=0 for 4 cycles, then 000.
- btn held high 5 cycles then released -> single press only, state 001. Press 4'b0011 as first digit, then correct remaining three -> FAIL.
- Two wrong codes back to back (lockout build) -> second FAIL goes to 110 with `locked`=1; presses ignored for 6 cycles; then 000; a correct code then reaches PASS.
- One press then idle 10 cycles -> 001 back to 000; fail count unchanged. A press on the 10th cycle -> 010 instead.
- Assert `rst` during GOT2 and during LOCK -> all outputs 0 asynchronously, state 000.
